// File: rtl/restoring_divider.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : restoring_divider                                          |
// | Description : Multi-cycle unsigned restoring divider. One shift cycle    |
// |               and one trial-subtract cycle per quotient bit, so a        |
// |               result is ready 2*WIDTH edges after the START capture edge.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//
// Ports
//   clk        in   rising-edge clock
//   n_reset    in   asynchronous active-low reset
//   START      in   start request in Idle, acknowledge in Stop
//   dividend   in   WIDTH  numerator, sampled on the capture edge only
//   divisor    in   WIDTH  denominator, sampled on the capture edge only
//   quotient   out  WIDTH  working/result quotient
//   remainder  out  WIDTH  working/result remainder
//   READY      out  high while results are held in Stop
//   DIVZERO    out  divide-by-zero flag, valid with READY
//
// Build option
//   DIVZERO_DETECT_EN : when defined, a zero divisor short-cuts to Stop one
//                       edge after capture with DIVZERO set. When undefined,
//                       DIVZERO stays 0 and a zero divisor runs the full
//                       algorithm, which yields the same quotient/remainder.
//------------------------------------------------------------------------------
`default_nettype none

module restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             START,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             READY,
    output logic             DIVZERO
);

    localparam int              CW           = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   C_COUNT_INIT = CW'(WIDTH);

`ifdef DIVZERO_DETECT_EN
    localparam bit              C_DZ_EN      = 1'b1;
`else
    localparam bit              C_DZ_EN      = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_SUB   = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;        // quotient / dividend shift register
    logic [WIDTH-1:0] d_q;        // captured divisor
    logic [WIDTH:0]   r_q;        // partial remainder, one guard bit
    logic [CW-1:0]    cnt_q;      // quotient bits still to produce
    logic             ready_q;
    logic             divz_q;

    logic [WIDTH:0]   r_diff_d;
    logic [CW-1:0]    cnt_d;
    logic             r_ge_d;

    assign r_diff_d = r_q - {1'b0, d_q};
    assign r_ge_d   = (r_q >= {1'b0, d_q});
    assign cnt_d    = cnt_q - CW'(1);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= C_COUNT_INIT;
            ready_q <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        q_q     <= dividend;
                        d_q     <= divisor;
                        r_q     <= '0;
                        cnt_q   <= C_COUNT_INIT;
                        state_q <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (C_DZ_EN && (d_q == '0)) begin
                        // Q still holds the untouched dividend here.
                        r_q     <= {1'b0, q_q};
                        q_q     <= '1;
                        divz_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        r_q     <= {r_q[WIDTH-1:0], q_q[WIDTH-1]};
                        q_q     <= {q_q[WIDTH-2:0], 1'b0};
                        state_q <= S_SUB;
                    end
                end

                S_SUB: begin
                    // Only commit the subtraction when it does not go
                    // negative; otherwise R is left as is (the restore).
                    if (r_ge_d) begin
                        r_q    <= r_diff_d;
                        q_q[0] <= 1'b1;
                    end
                    cnt_q <= cnt_d;
                    if (cnt_d == '0) begin
                        ready_q <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        state_q <= S_SHIFT;
                    end
                end

                S_STOP: begin
                    if (START) begin
                        q_q     <= '0;
                        d_q     <= '0;
                        r_q     <= '0;
                        cnt_q   <= C_COUNT_INIT;
                        ready_q <= 1'b0;
                        divz_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    q_q     <= '0;
                    d_q     <= '0;
                    r_q     <= '0;
                    cnt_q   <= C_COUNT_INIT;
                    ready_q <= 1'b0;
                    divz_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign quotient  = q_q;
    assign remainder = r_q[WIDTH-1:0];
    assign READY     = ready_q;
    assign DIVZERO   = divz_q;

endmodule

`default_nettype wire

// File: tb/tb_restoring_divider.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : tb_restoring_divider                                       |
// | Description : Self-checking bench for restoring_divider (WIDTH = 8):     |
// |               directed vector table, randomized operands against an      |
// |               arithmetic reference, reset and held-START sequences.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_restoring_divider;

    localparam int W = 8;

`ifdef DIVZERO_DETECT_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif
    localparam int ZLAT = DZ ? 1 : 16;

    logic         clk;
    logic         n_reset;
    logic         START;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         READY;
    logic         DIVZERO;

    int n_checks = 0;
    int n_err    = 0;

    restoring_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .START     (START),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .READY     (READY),
        .DIVZERO   (DIVZERO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic dz, output int lat);
        if (b == 0) begin
            q   = {W{1'b1}};
            r   = a;
            dz  = DZ;
            lat = ZLAT;
        end else begin
            q   = a / b;
            r   = a % b;
            dz  = 1'b0;
            lat = 2 * W;
        end
    endtask

    // Called at a negedge; counts rising edges until READY, bounded.
    task automatic wait_ready(input bit noise, output int edges);
        edges = 0;
        while (!READY && edges < 40) begin
            if (noise) START = 1'($urandom_range(1, 0));
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input int elat, input bit noise);
        int edges;
        @(negedge clk);
        START    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        START    = 1'b0;
        dividend = 8'($urandom);   // must not affect the running division
        divisor  = 8'($urandom);
        wait_ready(noise, edges);
        START = 1'b0;
        check({name, "_latency"}, edges, elat);
        check({name, "_quotient"}, quotient, eq);
        check({name, "_remainder"}, remainder, er);
        check({name, "_divzero"}, DIVZERO, edz);
        // Acknowledge and confirm results are cleared in Idle.
        START = 1'b1;
        @(posedge clk);
        @(negedge clk);
        START = 1'b0;
        check({name, "_ack_ready"}, READY, 0);
        check({name, "_ack_quotient"}, quotient, 0);
        check({name, "_ack_remainder"}, remainder, 0);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [W-1:0] a, b, eq, er;
        logic         edz;
        int           elat;
        int           edges;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 16};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 16};
        vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 16};
        vecs[3] = '{8'd200, 8'd200, 8'd1,   8'd0,  1'b0, 16};
        vecs[4] = '{8'd77,  8'd0,   8'hFF,  8'd77, DZ,   ZLAT};
        vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 16};
        vecs[6] = '{8'd1,   8'd255, 8'd0,   8'd1,  1'b0, 16};
        vecs[7] = '{8'd255, 8'd16,  8'd15,  8'd15, 1'b0, 16};
        vecs[8] = '{8'd0,   8'd0,   8'hFF,  8'd0,  DZ,   ZLAT};

        n_reset  = 1'b0;
        START    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", READY, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_divzero", DIVZERO, 0);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start_ready", READY, 0);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                  vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat, 1'b0);
        end

        // Randomized operands, START noise during the busy phase
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            case ($urandom_range(3, 0))
                0:       b = '0;
                1:       b = 8'($urandom_range(15, 1));
                default: b = 8'($urandom);
            endcase
            ref_div(a, b, eq, er, edz, elat);
            do_op($sformatf("rnd%0d", i), a, b, eq, er, edz, elat, 1'b1);
        end

        // Reset 5 edges into 100/7: partial results visible, then cleared
        // asynchronously away from any clock edge.
        @(negedge clk);
        START = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk);
        @(negedge clk);
        START = 1'b0;
        repeat (5) begin
            @(posedge clk);
        end
        #2;
        check("midop_quotient", quotient, 8'd32);
        check("midop_remainder", remainder, 8'd3);
        n_reset = 1'b0;
        #1;
        check("async_rst_quotient", quotient, 0);
        check("async_rst_remainder", remainder, 0);
        check("async_rst_ready", READY, 0);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_no_start_ready", READY, 0);
        check("post_rst_no_start_quotient", quotient, 0);
        do_op("after_reset", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 16, 1'b0);

        // START held high throughout: Stop -> Idle -> new operation.
        @(negedge clk);
        START = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk);
        @(negedge clk);
        dividend = 8'd3; divisor = 8'd1;
        wait_ready(1'b0, edges);
        check("held_latency1", edges, 16);
        check("held_quotient1", quotient, 8'd14);
        check("held_remainder1", remainder, 8'd2);
        @(posedge clk);
        @(negedge clk);
        check("held_idle_ready", READY, 0);
        check("held_idle_quotient", quotient, 0);
        dividend = 8'd200; divisor = 8'd200;
        @(posedge clk);
        @(negedge clk);
        check("held_busy_ready", READY, 0);
        dividend = 8'd9;
        wait_ready(1'b0, edges);
        check("held_latency2", edges, 16);
        check("held_quotient2", quotient, 8'd1);
        check("held_remainder2", remainder, 8'd0);
        @(posedge clk);
        @(negedge clk);
        START = 1'b0;
        check("held_final_idle_ready", READY, 0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
